// File: rtl/mem_arbiter.sv
// Shares the single-port rv32i memory between instruction fetch and load/store,
// one outstanding transaction at a time, with a response timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr_en,
  input  logic [3:0]        d_mask,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [3:0]        mem_mask,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_valid
);

  // Handshake: a requester holds x_req with stable fields until its one-cycle
  // x_gnt; each grant yields exactly one x_valid pulse unless reset aborts it.
  // mem_req is a one-cycle strobe; the first mem_valid seen in WAIT answers it.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             gnt_d;
  logic             last_d;
  logic [CNT_W-1:0] cnt;
  logic             grant_i;
  logic             grant_d;

  // Round-robin only matters on a conflict: the port not granted last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n && state == IDLE) begin
      if (i_req && d_req) begin
        grant_d = ~last_d;
        grant_i = last_d;
      end else begin
        grant_d = d_req;
        grant_i = i_req;
      end
    end
  end

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      last_d     <= 1'b0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wr_en  <= 1'b0;
      mem_mask   <= '0;
      mem_w_data <= '0;
      i_rdata    <= '0;
      i_valid    <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      i_err   <= 1'b0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            gnt_d   <= grant_d;
            last_d  <= grant_d;
            mem_req <= 1'b1;
            state   <= ISSUE;
            if (grant_d) begin
              mem_addr   <= d_addr;
              mem_wr_en  <= d_wr_en;
              mem_mask   <= d_mask;
              mem_w_data <= d_wdata;
            end else begin
              mem_addr   <= i_addr;
              mem_wr_en  <= 1'b0;
              mem_mask   <= '0;
              mem_w_data <= '0;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_valid) begin
            state <= IDLE;
            if (gnt_d) begin
              d_valid <= 1'b1;
              d_rdata <= mem_r_data;
            end else begin
              i_valid <= 1'b1;
              i_rdata <= mem_r_data;
            end
          end else if (cnt == CNT_LAST) begin
            // No answer within TIMEOUT WAIT cycles: error response, zero data.
            state <= IDLE;
            if (gnt_d) begin
              d_valid <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_valid <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_err;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_en;
  logic [3:0]        d_mask;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [3:0]        mem_mask;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;
  logic              mem_valid;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata),
    .i_valid(i_valid), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_mask(d_mask),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_mask(mem_mask), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_valid(mem_valid)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem_img [0:(1<<ADDR_W)-1];
  bit                mute       = 1'b0;
  int                lat_fixed  = 1;
  bit                stray_en   = 1'b0;
  int                stray_req  = 0;
  int                stray_done = 0;
  bit                pend       = 1'b0;
  int                sched      = 0;
  int                lat        = 0;
  int                lsel       = 0;
  logic [DATA_W-1:0] pend_data;

  initial begin
    mem_valid  = 1'b0;
    mem_r_data = '0;
  end

  always begin
    @(negedge clk);
    if (mem_req === 1'b1) begin
      pend_data = mem_img[mem_addr];
      if (mem_wr_en)
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem_img[mem_addr][8*b +: 8] = mem_w_data[8*b +: 8];
      if (lat_fixed > 0) lat = lat_fixed;
      else begin
        lsel = $urandom_range(0, 9);
        lat = (lsel < 4) ? 1 : (lsel < 6) ? 2 : (lsel == 6) ? 3 :
              (lsel == 7) ? TIMEOUT : (lsel == 8) ? TIMEOUT + 1 : 0;
      end
      pend  = !mute && lat > 0;
      sched = cyc + lat;
    end
    tick();
    mem_valid  = 1'b0;
    mem_r_data = $urandom;
    if (pend && cyc == sched) begin
      mem_valid  = 1'b1;
      mem_r_data = pend_data;
      pend       = 1'b0;
    end else if (stray_req != stray_done) begin
      stray_done = stray_req;
      mem_valid  = 1'b1;
      mem_r_data = 32'hDEADBEEF;
    end else if (!pend && stray_en && $urandom_range(0, 29) == 0) begin
      mem_valid = 1'b1;
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  // A transaction granted at cycle t issues at t+1, may be answered by any
  // mem_valid in cycles t+2 .. t+1+TIMEOUT, else times out at t+1+TIMEOUT;
  // its response appears one cycle after the answering cycle.
  logic [DATA_W+1:0] exp_q [$];   // {owner_is_d, err, data}
  bit                m_busy   = 1'b0;
  bit                m_owner_d = 1'b0;
  bit                m_last_d = 1'b0;
  int                m_t      = 0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic              m_wr     = 1'b0;
  logic [3:0]        m_mask   = '0;
  logic [DATA_W-1:0] m_wdata  = '0;
  logic [DATA_W-1:0] m_i_rdata = '0;
  logic [DATA_W-1:0] m_d_rdata = '0;

  always @(negedge clk) begin : cmp
    bit                e_ig, e_dg, e_iv, e_dv, e_ie, e_de, e_mreq;
    logic [DATA_W+1:0] r;
    e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_ie = 1'b0; e_de = 1'b0;
    if (rst_n && !m_busy) begin
      if (i_req && d_req) begin
        if (m_last_d) e_ig = 1'b1; else e_dg = 1'b1;
      end else begin
        e_ig = i_req;
        e_dg = d_req;
      end
    end
    e_mreq = m_busy && (cyc == m_t + 1);
    if (exp_q.size() > 0) begin
      r    = exp_q.pop_front();
      e_dv = r[DATA_W+1];
      e_iv = !r[DATA_W+1];
      e_de = e_dv && r[DATA_W];
      e_ie = e_iv && r[DATA_W];
    end
    if (chk_en) begin
      chk("i_gnt", i_gnt, e_ig);
      chk("d_gnt", d_gnt, e_dg);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr_en", mem_wr_en, m_wr);
      chk("mem_mask", mem_mask, m_mask);
      chk("mem_w_data", mem_w_data, m_wdata);
      chk("i_valid", i_valid, e_iv);
      chk("d_valid", d_valid, e_dv);
      chk("i_err", i_err, e_ie);
      chk("d_err", d_err, e_de);
      chk("i_rdata", i_rdata, m_i_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
    end
    if (!rst_n) begin
      m_busy = 1'b0; m_last_d = 1'b0; m_owner_d = 1'b0;
      m_addr = '0; m_wr = 1'b0; m_mask = '0; m_wdata = '0;
      m_i_rdata = '0; m_d_rdata = '0;
      exp_q.delete();
    end else if (e_ig || e_dg) begin
      m_busy    = 1'b1;
      m_t       = cyc;
      m_owner_d = e_dg;
      m_last_d  = e_dg;
      m_addr    = e_dg ? d_addr : i_addr;
      m_wr      = e_dg ? d_wr_en : 1'b0;
      m_mask    = e_dg ? d_mask : 4'b0000;
      m_wdata   = e_dg ? d_wdata : '0;
    end else if (m_busy && cyc >= m_t + 2) begin
      if (mem_valid) begin
        exp_q.push_back({m_owner_d, 1'b0, mem_r_data});
        if (m_owner_d) m_d_rdata = mem_r_data; else m_i_rdata = mem_r_data;
        m_busy = 1'b0;
      end else if (cyc == m_t + 1 + TIMEOUT) begin
        exp_q.push_back({m_owner_d, 1'b1, {DATA_W{1'b0}}});
        if (m_owner_d) m_d_rdata = '0; else m_i_rdata = '0;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    tick();
    i_req = 1'b0; d_req = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One isolated transaction with literal expectations on grant, issue and
  // the response cycle offset from the grant.
  task automatic xact(input string nm, input bit is_d, input bit wr,
                      input logic [ADDR_W-1:0] addr, input logic [3:0] mask,
                      input logic [DATA_W-1:0] wdata, input int exp_off,
                      input bit chk_data, input logic [DATA_W-1:0] exp_data,
                      input bit exp_err);
    int n;
    bit got;
    tick();
    if (is_d) begin
      d_req = 1'b1; d_addr = addr; d_wr_en = wr; d_mask = mask; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    chk({nm, "_gnt"}, is_d ? d_gnt : i_gnt, 1'b1);
    n = cyc;
    tick();
    i_req = 1'b0; d_req = 1'b0;
    i_addr = ~addr; d_addr = ~addr; d_wdata = $urandom; d_mask = ~mask;
    @(negedge clk);
    chk({nm, "_mem_req"}, mem_req, 1'b1);
    chk({nm, "_mem_addr"}, mem_addr, addr);
    chk({nm, "_mem_wr_en"}, mem_wr_en, is_d & wr);
    chk({nm, "_mem_mask"}, mem_mask, is_d ? mask : 4'b0000);
    chk({nm, "_mem_w_data"}, mem_w_data, is_d ? wdata : '0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      @(negedge clk);
      if (is_d ? d_valid : i_valid) got = 1'b1;
    end
    chk({nm, "_valid_seen"}, got, 1'b1);
    if (got) begin
      chk({nm, "_latency"}, cyc - n, exp_off);
      chk({nm, "_err"}, is_d ? d_err : i_err, exp_err);
      if (chk_data) chk({nm, "_rdata"}, is_d ? d_rdata : i_rdata, exp_data);
    end
  endtask

  // ---------------- main sequence ----------------
  bit ig_seen, dg_seen;
  int gcount, last_c, budget;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wr_en = 1'b0; d_mask = '0; d_wdata = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem_img[a] = '0;
    mem_img[12'h004] = 32'h00000013;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_i_valid", i_valid, 1'b0);
    chk("rst_d_rdata", d_rdata, '0);
    chk_en = 1'b1;

    xact("t1_fetch", 1'b0, 1'b0, 12'h004, 4'b0000, '0, 3, 1'b1, 32'h00000013, 1'b0);
    xact("t2_store", 1'b1, 1'b1, 12'h010, 4'b0011, 32'hAABBCCDD, 3, 1'b0, '0, 1'b0);
    xact("t2_load", 1'b1, 1'b0, 12'h010, 4'b1111, '0, 3, 1'b1, 32'h0000CCDD, 1'b0);

    stray_req++;
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    chk("t6_i_valid", i_valid, 1'b0);
    chk("t6_d_valid", d_valid, 1'b0);
    chk("t6_i_rdata", i_rdata, 32'h00000013);
    chk("t6_d_rdata", d_rdata, 32'h0000CCDD);

    mute = 1'b1;
    xact("t4_timeout", 1'b1, 1'b0, 12'h020, 4'b0000, '0, TIMEOUT + 2, 1'b1, '0, 1'b1);
    mute = 1'b0;
    xact("t4_after", 1'b0, 1'b0, 12'h004, 4'b0000, '0, 3, 1'b1, 32'h00000013, 1'b0);

    // Both ports held: grants must alternate d,i,d,i three cycles apart.
    do_reset();
    i_req = 1'b1; i_addr = 12'h004; d_req = 1'b1; d_addr = 12'h010; d_wr_en = 1'b0;
    gcount = 0; last_c = 0; budget = 0;
    while (gcount < 4 && budget < 40) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        chk("t3_single_grant", i_gnt & d_gnt, 1'b0);
        chk("t3_owner_is_d", d_gnt, (gcount % 2) == 0);
        if (gcount > 0) chk("t3_gap", cyc - last_c, 3);
        last_c = cyc;
        gcount++;
      end
      budget++;
      tick();
    end
    chk("t3_grants_seen", gcount, 4);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    // Reset while waiting; the memory's answer lands the cycle after reset.
    lat_fixed = 2;
    i_req = 1'b1; i_addr = 12'h004;
    @(negedge clk);
    chk("t5_gnt", i_gnt, 1'b1);
    tick(); i_req = 1'b0;
    @(negedge clk);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_i_valid", i_valid, 1'b0);
    chk("t5_d_valid", d_valid, 1'b0);
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_mem_addr", mem_addr, '0);
    chk("t5_i_rdata", i_rdata, '0);
    tick();
    @(negedge clk);
    chk("t5_late_i_valid", i_valid, 1'b0);
    chk("t5_late_i_rdata", i_rdata, '0);

    // Randomized traffic with stray responses, long latencies and resets.
    lat_fixed = 0;
    stray_en  = 1'b1;
    ig_seen = 1'b0; dg_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      if (i_req && !ig_seen) begin
        if ($urandom_range(0, 31) == 0) i_req = 1'b0;
      end else begin
        i_req  = ($urandom_range(0, 1) == 1);
        i_addr = ADDR_W'($urandom_range(0, 63));
      end
      if (d_req && !dg_seen) begin
        if ($urandom_range(0, 31) == 0) d_req = 1'b0;
      end else begin
        d_req   = ($urandom_range(0, 1) == 1);
        d_addr  = ADDR_W'($urandom_range(0, 63));
        d_wr_en = ($urandom_range(0, 1) == 1);
        d_mask  = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      @(negedge clk);
      ig_seen = i_gnt;
      dg_seen = d_gnt;
    end
    tick();
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; stray_en = 1'b0;
    repeat (TIMEOUT + 10) tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port unified rv32i memory. It shares the memory between the instruction-fetch port (read-only) and the load/store data port. It latches one request at a time, drives the memory's req/wr_en/mask/w_data/mem_addr, waits for the memory's valid, and routes r_data back to the granted requester. A timeout reports an error if the memory never answers.

Parameters:
ADDR_W, 12, word-address width (matches mem_addr)
DATA_W, 32, data width
TIMEOUT, 16, max cycles in BUSY without mem_valid before an error response (>=2)

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  reset, synchronous, active-low
i_req  input  1  fetch request; held until i_gnt
i_addr  input  ADDR_W  fetch address
i_gnt  output  1  one-cycle pulse: fetch request accepted
i_rdata  output  DATA_W  fetch read data, valid with i_valid
i_valid  output  1  one-cycle pulse: fetch response
i_err  output  1  with i_valid: timeout, i_rdata=0
d_req  input  1  data request; held until d_gnt
d_addr  input  ADDR_W  data address
d_wr_en  input  1  1=store, 0=load
d_mask  input  4  byte-lane write mask
d_wdata  input  DATA_W  store data
d_gnt  output  1  one-cycle pulse: data request accepted
d_rdata  output  DATA_W  load data, valid with d_valid
d_valid  output  1  one-cycle pulse: data response (loads and stores)
d_err  output  1  with d_valid: timeout, d_rdata=0
mem_req  output  1  memory request, one-cycle pulse
mem_addr  output  ADDR_W  latched address
mem_wr_en  output  1  latched write enable (0 for fetch)
mem_mask  output  4  latched mask (4'b0000 for fetch)
mem_w_data  output  DATA_W  latched write data (0 for fetch)
mem_r_data  input  DATA_W  memory read data
mem_valid  input  1  memory response

Behaviour:
- States: IDLE, ISSUE, WAIT. A register gnt_d (1=data, 0=fetch) records the owner. A register last_d records the last grant.
- Reset (rst_n=0 at posedge): state=IDLE, last_d=0, timeout counter=0. All outputs 0: gnt, valid, err, rdata, mem_req, mem_addr, mem_wr_en, mem_mask, mem_w_data.
- Reset mid-transaction aborts. No valid pulse is emitted, and a late mem_valid after reset is ignored.
- IDLE, no req: stay.
- IDLE, one req: grant it.
- IDLE, both req: round-robin. Grant data if last_d=0, else fetch. First conflict after reset therefore goes to data.
- Grant cycle: pulse x_gnt combinationally in that IDLE cycle. Latch addr/wr_en/mask/wdata into mem_* registers, set gnt_d, update last_d, and go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle; the counter clears. Next state is WAIT.
- WAIT: mem_req=0. The counter increments each cycle.
  - On mem_valid=1: register mem_r_data into x_rdata, pulse x_valid=1 next cycle (err=0), return to IDLE.
  - If the counter reaches TIMEOUT without mem_valid: pulse x_valid=1 and x_err=1 with x_rdata=0, return to IDLE.
- mem_valid in IDLE or ISSUE is ignored.
- x_rdata holds its last value between responses. The other port's rdata is unchanged.
- Stores still wait for mem_valid and produce d_valid. d_rdata is loaded with mem_r_data; its content is don't-care to the requester.
- Latency with a 1-cycle memory:
  - grant at cycle N, mem_req at N+1, mem_valid at N+2, x_valid at N+3.
  - Next grant is no earlier than N+3, because IDLE is re-entered at N+3.
  - Max throughput is one transaction per 3 cycles.
- Requester fields may change after x_gnt without affecting the transaction in flight.
- A req dropped before gnt is simply never granted; no error is raised.
- Only one transaction is ever outstanding. i_valid and d_valid are never high in the same cycle.

Test Plan:
1. Reset, then i_req=1, i_addr=0x004, memory returns 0x00000013 -> i_gnt at N, mem_req at N+1 with mem_addr=0x004 and mem_wr_en=0, i_valid=1 with i_rdata=0x00000013 at N+3, i_err=0.
2. d_req store d_addr=0x010, d_mask=4'b0011, d_wdata=0xAABBCCDD -> mem_wr_en=1, mem_mask=4'b0011, mem_w_data=0xAABBCCDD on the mem_req cycle; d_valid pulse at N+3; a following load from 0x010 returns 0x0000CCDD when memory initialised to 0.
3. i_req and d_req held continuously after reset -> grants alternate d,i,d,i, each 3 cycles apart; no double grant.
4. Memory model never asserts mem_valid, TIMEOUT=16 -> after 16 WAIT cycles d_valid=1, d_err=1, d_rdata=0; the arbiter returns to IDLE and grants the next request normally.
5. rst_n=0 during WAIT, then memory asserts mem_valid the next cycle -> no i_valid/d_valid pulse, all outputs 0, state IDLE.
6. Stray mem_valid=1 while IDLE with no requests -> no valid pulse; rdata outputs unchanged.
